// File: rtl/system_timer_pkg.sv
// Shared register map and bit positions for the system timer.
// Imported by the timer top and by anything that decodes its registers.
package system_timer_pkg;

   localparam logic [2:0] ADDR_STATUS   = 3'd0;
   localparam logic [2:0] ADDR_CONTROL  = 3'd1;
   localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
   localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
   localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
   localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

   localparam int STAT_TO    = 0;
   localparam int STAT_RUN   = 1;
   localparam int CTRL_ITO   = 0;
   localparam int CTRL_CONT  = 1;
   localparam int CTRL_START = 2;
   localparam int CTRL_STOP  = 3;

   function automatic logic is_period_addr(input logic [2:0] a);
      return (a == ADDR_PERIOD_L) || (a == ADDR_PERIOD_H);
   endfunction

   function automatic logic is_snap_addr(input logic [2:0] a);
      return (a == ADDR_SNAP_L) || (a == ADDR_SNAP_H);
   endfunction

endpackage

// File: rtl/system_timer_gen2_if.sv
// Register bus of the system timer: word-addressed, 1-cycle registered read.
// Handshake: a write happens on any edge where chipselect=1 and write_n=0; no stalls.
interface system_timer_gen2_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic [15:0] readdata;
   logic        irq;

   modport master (output address, chipselect, write_n, writedata,
                   input  readdata, irq);
   modport slave  (input  address, chipselect, write_n, writedata,
                   output readdata, irq);
endinterface

// File: rtl/system_timer_core.sv
// Down-counter with period reload and zero detect.
// force_reload has priority over counting and loads period regardless of run.
module system_timer_core #(
   parameter int                 COUNT_W     = 32,
   parameter logic [COUNT_W-1:0] RESET_COUNT = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   input  logic               force_reload,
   input  logic [COUNT_W-1:0] period,
   output logic [COUNT_W-1:0] count,
   output logic               zero
);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= RESET_COUNT;
      end else if (force_reload) begin
         count <= period;
      end else if (run) begin
         if (count == '0) count <= period;
         else             count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/system_timer_gen2.sv
// Programmable interval timer: register file, control strobes and read mux.
// Counting itself lives in system_timer_core.
module system_timer_gen2
   import system_timer_pkg::*;
#(
   parameter int COUNT_W        = 32,
   parameter int DEFAULT_PERIOD = 499,
   parameter bit AUTO_START     = 1'b1,
   parameter bit DEFAULT_CONT   = 1'b1
) (
   input logic                clk,
   input logic                reset,
   system_timer_gen2_if.slave bus
);

   localparam logic [COUNT_W-1:0] RESET_PERIOD = COUNT_W'(DEFAULT_PERIOD);

   logic [COUNT_W-1:0] period;
   logic [COUNT_W-1:0] snapshot;
   logic [COUNT_W-1:0] count;
   logic               zero;
   logic               run, run_next;
   logic               cont, ito, to;
   logic               force_reload;
   logic               wr, status_wr, ctrl_wr, period_wr, snap_wr;
   logic               start, stop, timeout;
   logic [15:0]        rd_mux;

   assign wr        = bus.chipselect & ~bus.write_n;
   assign status_wr = wr && (bus.address == ADDR_STATUS);
   assign ctrl_wr   = wr && (bus.address == ADDR_CONTROL);
   assign period_wr = wr && is_period_addr(bus.address);
   assign snap_wr   = wr && is_snap_addr(bus.address);
   assign start     = ctrl_wr & bus.writedata[CTRL_START];
   assign stop      = ctrl_wr & bus.writedata[CTRL_STOP];
   assign timeout   = run & zero & ~force_reload;

   // Later assignments win: period write over STOP over START over one-shot expiry.
   always_comb begin
      run_next = run;
      if (timeout && !cont) run_next = 1'b0;
      if (stop)                  run_next = 1'b0;
      else if (start && !run)    run_next = 1'b1;
      if (period_wr)             run_next = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         period       <= RESET_PERIOD;
         snapshot     <= '0;
         run          <= AUTO_START;
         cont         <= DEFAULT_CONT;
         ito          <= 1'b0;
         to           <= 1'b0;
         force_reload <= 1'b0;
      end else begin
         run          <= run_next;
         force_reload <= period_wr;
         if (ctrl_wr) begin
            ito  <= bus.writedata[CTRL_ITO];
            cont <= bus.writedata[CTRL_CONT];
         end
         if (wr && bus.address == ADDR_PERIOD_L) period[15:0] <= bus.writedata;
         if (wr && bus.address == ADDR_PERIOD_H)
            period[COUNT_W-1:16] <= bus.writedata[COUNT_W-17:0];
         if (snap_wr) snapshot <= count;
         if (timeout)        to <= 1'b1;
         else if (status_wr) to <= 1'b0;
      end
   end

   system_timer_core #(
      .COUNT_W     (COUNT_W),
      .RESET_COUNT (RESET_PERIOD)
   ) u_core (
      .clk          (clk),
      .reset        (reset),
      .run          (run),
      .force_reload (force_reload),
      .period       (period),
      .count        (count),
      .zero         (zero)
   );

   always_comb begin
      rd_mux = '0;
      case (bus.address)
         ADDR_STATUS: begin
            rd_mux[STAT_RUN] = run;
            rd_mux[STAT_TO]  = to;
         end
         ADDR_CONTROL: begin
            rd_mux[CTRL_CONT] = cont;
            rd_mux[CTRL_ITO]  = ito;
         end
         ADDR_PERIOD_L: rd_mux = period[15:0];
         ADDR_PERIOD_H: rd_mux[COUNT_W-17:0] = period[COUNT_W-1:16];
         ADDR_SNAP_L:   rd_mux = snapshot[15:0];
         ADDR_SNAP_H:   rd_mux[COUNT_W-17:0] = snapshot[COUNT_W-1:16];
         default:       rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) bus.readdata <= '0;
      else       bus.readdata <= rd_mux;
   end

   assign bus.irq = to & ito;

endmodule

// File: doc/system_timer_gen2.md
SYSTEM_TIMER_GEN2 -- requirements
Module: system_timer_gen2

Interface
REQ-001 SHALL have parameter COUNT_W, default 32, counter/period width (legal 17..32).
REQ-002 SHALL have parameter DEFAULT_PERIOD, default 499, reset value of period and counter (truncated to COUNT_W).
REQ-003 SHALL have parameter AUTO_START, default 1, RUN state after reset.
REQ-004 SHALL have parameter DEFAULT_CONT, default 1, CONT bit after reset.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port address  input  3  register word select.
REQ-008 SHALL have port chipselect  input  1  slave select.
REQ-009 SHALL have port write_n  input  1  active-low write strobe.
REQ-010 SHALL have port writedata  input  16  write data.
REQ-011 SHALL have port readdata  output  16  registered read data.
REQ-012 SHALL have port irq  output  1  level interrupt.

Function
REQ-013 SHALL decode a write as chipselect & ~write_n; the register map is 0 STATUS, 1 CONTROL, 2 PERIOD_L, 3 PERIOD_H, 4 SNAP_L, 5 SNAP_H; addresses 6-7 read 0 and ignore writes.
REQ-014 SHALL register readdata every cycle from the address mux regardless of chipselect (1-cycle read latency).
REQ-015 SHALL read STATUS as {14'b0, RUN, TO}; CONTROL as {14'b0, CONT, ITO}; PERIOD_L/H as period[15:0] / period[COUNT_W-1:16] zero-extended; SNAP_L/H as the same slices of the snapshot.
REQ-016 SHALL treat CONTROL writedata bits 0 ITO and 1 CONT as stored bits, bit 2 START and bit 3 STOP as self-clearing strobes.
REQ-017 SHALL, while RUN=1 and counter!=0, decrement the counter by 1 each cycle.
REQ-018 SHALL, while RUN=1 and counter==0, on the next edge reload counter with period and set TO; clear RUN if CONT=0 (one-shot), keep it set if CONT=1, giving a timeout period of period+1 cycles.
REQ-019 SHALL hold the counter unchanged while RUN=0.
REQ-020 SHALL set RUN on START and clear it on STOP; START while running has no effect (no restart); START and STOP in the same write: STOP wins.
REQ-021 SHALL, on a write to PERIOD_L or PERIOD_H, update the addressed slice, clear RUN, and on the following cycle load the counter with the new period (force reload).
REQ-022 SHALL ignore PERIOD_H writedata bits above COUNT_W-17.
REQ-023 SHALL, on any write to SNAP_L or SNAP_H, capture the current counter value into the snapshot register at that edge.
REQ-024 SHALL clear TO on a STATUS write; when a timeout and a STATUS write coincide, TO ends set (set wins).
REQ-025 SHALL drive irq = TO & ITO combinationally from registered state.

Reset
REQ-026 SHALL on reset set counter = period = DEFAULT_PERIOD, RUN = AUTO_START, CONT = DEFAULT_CONT, ITO = 0, TO = 0, snapshot = 0, readdata = 0, force-reload = 0; irq = 0 follows.
REQ-027 SHALL have reset asserted mid-count abort counting immediately, discarding any pending strobe or reload.

Structure
REQ-028 SHALL take register address constants (ADDR_STATUS..ADDR_SNAP_H) and control/status bit positions from the shared package system_timer_pkg.
REQ-029 SHALL implement the down-counter, reload and zero-detect in one sub-module, system_timer_core (parameter COUNT_W; inputs run, force_reload, period; outputs count, zero); the register file, strobes and read mux stay in the top.

Verification
REQ-030 SHALL cover: reset with defaults, no writes, ITO=1 written at cycle 1 -> TO first sets 500 cycles after reset release, then every 500 cycles; irq high from first TO.
REQ-031 SHALL cover: write CONTROL=0x8 (STOP), PERIOD_L=9, PERIOD_H=0, CONTROL=0x4 (START, CONT=0) -> exactly one timeout 10 cycles after START, then RUN=0, counter=9.
REQ-032 SHALL cover: COUNT_W=32, write PERIOD_L=0x0000 and PERIOD_H=0x0001 -> PERIOD_H reads 0x0001, RUN=0 after the write; after START, SNAP write at 5 cycles reads snapshot 0x0000FFFC.
REQ-033 SHALL cover: STATUS write on the exact cycle of a timeout with period 3 -> TO reads 1; STATUS write one cycle later -> TO reads 0 and irq drops the cycle after.
REQ-034 SHALL cover: CONTROL=0xC (START|STOP) while stopped -> RUN stays 0; START while running at counter 200 -> counting continues uninterrupted.
REQ-035 SHALL cover: reset asserted for one cycle mid-count -> all registers at REQ-026 values and readdata=0 next cycle.
